// File: rtl/dma_buffer_push_arbiter.sv
// Round-robin arbiter sharing one registered FIFO push port between N_CH valid/ready
// producers, granting bursts of up to MAX_BURST beats and throttling on full/alm_full.
module dma_buffer_push_arbiter #(
  parameter int N_CH      = 4,
  parameter int MAX_BURST = 4,
  parameter int DATA_W    = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic [N_CH-1:0]        ch_valid_i,
  input  logic [N_CH*DATA_W-1:0] ch_data_i,
  output logic [N_CH-1:0]        ch_ready_o,
  output logic                   fifo_push_o,
  output logic [DATA_W-1:0]      fifo_data_o,
  input  logic                   fifo_full_i,
  input  logic                   fifo_alm_full_i,
  output logic [N_CH-1:0]        src_o
);
  localparam int IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(N_CH - 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t            state_reg;
  logic [IDX_W-1:0]  last_reg;
  logic [IDX_W-1:0]  own_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [DATA_W-1:0] ch_data [N_CH];

  logic             can_accept;
  logic             found;
  logic             grant_valid;
  logic [IDX_W-1:0] winner;
  logic [IDX_W-1:0] grant;
  logic [CNT_W-1:0] cnt_inc;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_unpack
      assign ch_data[gi] = ch_data_i[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // A push already in flight onto an almost-full FIFO fills it, so no accept that cycle.
  assign can_accept = !rst_i && !flush_i && !fifo_full_i && !(fifo_alm_full_i && fifo_push_o);

  always_comb begin
    int idx;
    logic [IDX_W-1:0] cand;
    found  = 1'b0;
    winner = last_reg;
    idx    = 0;
    cand   = '0;
    for (int off = 1; off <= N_CH; off++) begin
      idx  = (int'(last_reg) + off) % N_CH;
      cand = IDX_W'(idx);
      if (!found && ch_valid_i[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    grant_valid = 1'b0;
    grant       = own_reg;
    if (state_reg == IDLE) begin
      grant_valid = found && can_accept;
      grant       = winner;
    end else begin
      grant_valid = ch_valid_i[own_reg] && can_accept;
    end
  end

  assign cnt_inc = cnt_reg + CNT_W'(1);

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ready
      assign ch_ready_o[gi] = grant_valid && (grant == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      state_reg   <= IDLE;
      last_reg    <= LAST_RST;
      own_reg     <= LAST_RST;
      cnt_reg     <= '0;
      fifo_push_o <= 1'b0;
      fifo_data_o <= '0;
      src_o       <= '0;
    end else begin
      fifo_push_o <= grant_valid;
      src_o       <= ch_ready_o;
      if (grant_valid) begin
        fifo_data_o <= ch_data[grant];
      end
      case (state_reg)
        IDLE: begin
          if (grant_valid) begin
            last_reg <= winner;
            own_reg  <= winner;
            cnt_reg  <= CNT_W'(1);
            if (MAX_BURST > 1) begin
              state_reg <= BURST;
            end
          end
        end
        BURST: begin
          // Owner going idle releases the lock; that cycle is a bubble.
          if (!ch_valid_i[own_reg]) begin
            state_reg <= IDLE;
          end else if (grant_valid) begin
            cnt_reg <= cnt_inc;
            if (cnt_inc == CNT_W'(MAX_BURST)) begin
              state_reg <= IDLE;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dma_buffer_push_arbiter.sv
// Scoreboard bench: stimulus queues the expected (cycle, source, data) of each push;
// negedge monitors pop and compare against both DUT instances.
module tb_dma_buffer_push_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  typedef struct packed {
    logic [31:0] cyc;
    logic [3:0]  src;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst, flush;
  logic [N-1:0] valid, valid1;
  logic [N*W-1:0] ch_data;
  logic [N-1:0] ready, ready1;
  logic push, push1;
  logic [W-1:0] data, data1;
  logic [N-1:0] src, src1;
  logic full, alm_full, pop, model_en;
  int fcount;

  int cyc;
  int checks;
  int failures;
  exp_t q0[$];
  exp_t q1[$];

  dma_buffer_push_arbiter #(.N_CH(N), .MAX_BURST(4), .DATA_W(W)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ch_valid_i(valid), .ch_data_i(ch_data), .ch_ready_o(ready),
    .fifo_push_o(push), .fifo_data_o(data),
    .fifo_full_i(full), .fifo_alm_full_i(alm_full), .src_o(src)
  );

  dma_buffer_push_arbiter #(.N_CH(N), .MAX_BURST(1), .DATA_W(W)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .flush_i(1'b0),
    .ch_valid_i(valid1), .ch_data_i(ch_data), .ch_ready_o(ready1),
    .fifo_push_o(push1), .fifo_data_o(data1),
    .fifo_full_i(1'b0), .fifo_alm_full_i(1'b0), .src_o(src1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Depth-4 FIFO occupancy model, only active during the backpressure test.
  always @(posedge clk) begin
    if (!model_en) fcount <= 0;
    else fcount <= fcount + (push ? 1 : 0) - (pop ? 1 : 0);
  end
  assign full     = model_en && (fcount == 4);
  assign alm_full = model_en && (fcount == 3);

  function automatic logic [31:0] dv(int k, int c);
    return {8'(k), 24'(c)};
  endfunction

  task automatic chk(string name, logic [71:0] act, logic [71:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < N; k++) ch_data[k*W +: W] = dv(k, cyc);
  endtask

  task automatic exp_main(int k);
    exp_t e;
    e.cyc = 32'(cyc + 1);
    e.src = 4'(1 << k);
    e.data = dv(k, cyc);
    q0.push_back(e);
  endtask

  task automatic exp_mb1(int k);
    exp_t e;
    e.cyc = 32'(cyc + 1);
    e.src = 4'(1 << k);
    e.data = dv(k, cyc);
    q1.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (model_en) chk("no_push_while_full", {71'd0, full && push}, 72'd0);
      if (push) begin
        if (q0.size() == 0) begin
          checks++; failures++;
          $display("FAIL main_unexpected_push cyc=%0d src=%b data=%h required=no push", cyc, src, data);
        end else begin
          e = q0.pop_front();
          chk("main_push", {32'(cyc), src, data}, {e.cyc, e.src, e.data});
        end
      end else if (q0.size() > 0 && int'(q0[0].cyc) <= cyc) begin
        e = q0.pop_front();
        checks++; failures++;
        $display("FAIL main_missing_push cyc=%0d actual=no push required src=%b data=%h", cyc, e.src, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (push1) begin
        if (q1.size() == 0) begin
          checks++; failures++;
          $display("FAIL mb1_unexpected_push cyc=%0d src=%b required=no push", cyc, src1);
        end else begin
          e = q1.pop_front();
          chk("mb1_push", {32'(cyc), src1, data1}, {e.cyc, e.src, e.data});
        end
      end else if (q1.size() > 0 && int'(q1[0].cyc) <= cyc) begin
        e = q1.pop_front();
        checks++; failures++;
        $display("FAIL mb1_missing_push cyc=%0d actual=no push required src=%b", cyc, e.src);
      end
    end
  end

  initial begin
    int ch;
    cyc = 0; checks = 0; failures = 0;
    rst = 1'b1; flush = 1'b0; valid = '0; valid1 = '0; pop = 1'b0; model_en = 1'b0;
    for (int k = 0; k < N; k++) ch_data[k*W +: W] = dv(k, 0);

    // Reset: no ready even with every producer valid; outputs cleared.
    step(); step();
    valid = 4'hF; valid1 = 4'hF;
    #1;
    chk("reset_ready", 72'(ready), 72'd0);
    chk("reset_ready_mb1", 72'(ready1), 72'd0);
    step();
    chk("reset_outputs", {push, src, data}, 72'd0);
    rst = 1'b0; valid = '0; valid1 = '0;
    step(); step();

    // Fairness: bursts of 4 rotating; MAX_BURST=1 instance rotates every beat.
    for (int i = 0; i < 20; i++) begin
      ch = (i / 4) % 4;
      valid = 4'hF;
      valid1 = (i < 8) ? 4'hF : 4'h0;
      exp_main(ch);
      if (i < 8) exp_mb1(i % 4);
      #1;
      chk("fair_ready", 72'(ready), 72'(1 << ch));
      if (i < 8) chk("mb1_ready", 72'(ready1), 72'(1 << (i % 4)));
      step();
    end
    valid = '0; valid1 = '0;
    step(); step(); step();

    // Single producer ch2: 20 back-to-back beats across burst boundaries.
    valid = 4'b0100;
    for (int i = 0; i < 20; i++) begin
      exp_main(2);
      step();
    end
    valid = '0;
    step(); step(); step();

    // Backpressure against a stalled depth-4 FIFO.
    valid = 4'b0001; model_en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_main(0);
      step();
    end
    #1;
    chk("bp_almfull_inflight", 72'({alm_full, push}), 72'd3);
    chk("bp_ready_drop", 72'(ready), 72'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      chk("bp_ready_full", 72'(ready), 72'd0);
    end
    pop = 1'b1;
    step();
    pop = 1'b0;
    #1;
    chk("bp_one_slot_ready", 72'(ready), 72'd1);
    exp_main(0);
    step();
    #1;
    chk("bp_refill_ready", 72'(ready), 72'd0);
    step();
    #1;
    chk("bp_full_again_ready", 72'(ready), 72'd0);
    valid = '0;
    step();
    model_en = 1'b0;
    step(); step();

    // Early release: ch1 drops after 2 beats, one bubble, then ch3 for 4 beats.
    valid = 4'b1010;
    exp_main(1); step();
    exp_main(1); step();
    valid = 4'b1000;
    #1;
    chk("early_bubble", 72'(ready), 72'd0);
    step();
    for (int i = 0; i < 4; i++) begin
      exp_main(3);
      #1;
      chk("early_ch3_ready", 72'(ready), 72'd8);
      step();
    end
    // last=3 means ch0 beats ch3 next.
    valid = 4'b1001;
    exp_main(0);
    #1;
    chk("last_wrap_ready", 72'(ready), 72'd1);
    step();
    valid = '0;
    step(); step();

    // Flush mid-burst: ch2 locked at cnt=2.
    valid = 4'b0100;
    exp_main(2); step();
    exp_main(2); step();
    valid = 4'hF; flush = 1'b1;
    #1;
    chk("flush_ready", 72'(ready), 72'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flush_outputs", {push, src, data}, 72'd0);
    chk("flush_regrant", 72'(ready), 72'd1);
    exp_main(0);
    step();
    valid = '0;
    step(); step(); step();

    chk("q0_drained", 72'(q0.size()), 72'd0);
    chk("q1_drained", 72'(q1.size()), 72'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
